// File: rtl/address_register_bank_if.sv
// Bus interface for address_register_bank.
//
// Groups the control, load-data and read-port signals of the address register
// bank. Clock and reset are not part of this interface; they are plain ports
// on the bank itself.
//
//   master modport : the controller side. It drives i, reg_sel, fun_sel,
//                    push, pop, clear_flags, out_c_sel and out_d_sel, and
//                    observes out_c, out_d, stack_overflow and stack_underflow.
//   slave modport  : the register bank side, with the opposite directions.
//
// Parameters:
//   WIDTH    - register and data width.
//   NUM_REGS - number of registers (0 = PC, 1 = SP, 2.. = AR).
interface address_register_bank_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4
);
  localparam int SELW = $clog2(NUM_REGS);

  logic [WIDTH-1:0]    i;
  logic [NUM_REGS-1:0] reg_sel;
  logic [1:0]          fun_sel;
  logic                push;
  logic                pop;
  logic                clear_flags;
  logic [SELW-1:0]     out_c_sel;
  logic [SELW-1:0]     out_d_sel;
  logic [WIDTH-1:0]    out_c;
  logic [WIDTH-1:0]    out_d;
  logic                stack_overflow;
  logic                stack_underflow;

  modport master (
    output i, reg_sel, fun_sel, push, pop, clear_flags, out_c_sel, out_d_sel,
    input  out_c, out_d, stack_overflow, stack_underflow
  );

  modport slave (
    input  i, reg_sel, fun_sel, push, pop, clear_flags, out_c_sel, out_d_sel,
    output out_c, out_d, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/address_register_bank.sv
// Parametrised address register bank.
//
// The bank holds NUM_REGS address registers of WIDTH bits:
//   - register 0 is the PC,
//   - register 1 is the SP,
//   - registers 2 and up are general address registers (AR0, AR1, ...).
//
// Each register whose reg_sel bit is set applies fun_sel:
//   00 clear, 01 load i, 10 increment, 11 decrement.
// Increment and decrement wrap modulo 2^WIDTH.
//
// push and pop act on SP and take priority over fun_sel. With both of them
// asserted, SP holds its value.
//
// There are two registered read ports. out_c and out_d sample
// reg[out_c_sel] and reg[out_d_sel] from the register values before the edge.
// A select index outside the register range reads as 0.
//
// Optional feature, enabled by defining the macro ADDR_STACK_BOUNDS_EN:
//   push at SP_MIN and pop at SP_MAX leave SP unchanged and set the sticky
//   stack_overflow or stack_underflow flag. clear_flags clears both flags;
//   a violation in the same cycle as clear_flags still sets its flag.
// With the macro undefined, push and pop simply wrap, both flags are tied to
// 0 and clear_flags has no effect.
//
// Ports:
//   clock   - clock; all state changes on the rising edge.
//   reset_n - synchronous, active-low reset.
//   bus     - address_register_bank_if.slave (controls, load data, read ports).
module address_register_bank #(
  parameter int              WIDTH    = 16,
  parameter int              NUM_REGS = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0,
  parameter logic [WIDTH-1:0] SP_RESET = 16'h00FF,
  parameter logic [WIDTH-1:0] SP_MIN   = 16'h0080,
  parameter logic [WIDTH-1:0] SP_MAX   = 16'h00FF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  address_register_bank_if.slave  bus
);
  localparam int SELW   = $clog2(NUM_REGS);
  localparam int PC_IDX = 0;
  localparam int SP_IDX = 1;

  typedef enum logic [1:0] {
    FUN_CLEAR = 2'b00,
    FUN_LOAD  = 2'b01,
    FUN_INC   = 2'b10,
    FUN_DEC   = 2'b11
  } fun_e;

  // Reject parameter sets that cannot describe a PC, an SP and at least one AR,
  // or that would start the stack outside its own legal range.
  if (NUM_REGS < 3) begin : g_bad_num_regs
    $error("address_register_bank: NUM_REGS must be at least 3");
  end
  if (SP_RESET < SP_MIN || SP_RESET > SP_MAX) begin : g_bad_sp_reset
    $error("address_register_bank: SP_RESET must lie in [SP_MIN, SP_MAX]");
  end

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [WIDTH-1:0] out_d_q, out_d_d;

`ifdef ADDR_STACK_BOUNDS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    regs_d = regs_q;

    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.reg_sel[k]) begin
        unique case (fun_e'(bus.fun_sel))
          FUN_CLEAR: regs_d[k] = '0;
          FUN_LOAD:  regs_d[k] = bus.i;
          FUN_INC:   regs_d[k] = regs_q[k] + WIDTH'(1);
          FUN_DEC:   regs_d[k] = regs_q[k] - WIDTH'(1);
        endcase
      end
    end

`ifdef ADDR_STACK_BOUNDS_EN
    // Sticky flags: clear first, so that a violation in this same cycle
    // still sets its flag.
    ovf_d = ovf_q & ~bus.clear_flags;
    unf_d = unf_q & ~bus.clear_flags;
`endif

    // Any stack operation takes SP away from fun_sel. push together with pop
    // therefore leaves SP at its old value.
    if (bus.push || bus.pop) begin
      regs_d[SP_IDX] = regs_q[SP_IDX];
      if (bus.push && !bus.pop) begin
`ifdef ADDR_STACK_BOUNDS_EN
        if (regs_q[SP_IDX] == SP_MIN) ovf_d = 1'b1;
        else                          regs_d[SP_IDX] = regs_q[SP_IDX] - WIDTH'(1);
`else
        regs_d[SP_IDX] = regs_q[SP_IDX] - WIDTH'(1);
`endif
      end else if (bus.pop && !bus.push) begin
`ifdef ADDR_STACK_BOUNDS_EN
        if (regs_q[SP_IDX] == SP_MAX) unf_d = 1'b1;
        else                          regs_d[SP_IDX] = regs_q[SP_IDX] + WIDTH'(1);
`else
        regs_d[SP_IDX] = regs_q[SP_IDX] + WIDTH'(1);
`endif
      end
    end

    // The loop only matches indices that exist, so an out-of-range select
    // keeps the default value of 0.
    out_c_d = '0;
    out_d_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.out_c_sel == SELW'(k)) out_c_d = regs_q[k];
      if (bus.out_d_sel == SELW'(k)) out_d_d = regs_q[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // NOTE: the register array is a handful of flops with architecturally
      // defined reset values, not a RAM, so every entry is reset explicitly.
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      regs_q[PC_IDX] <= PC_RESET;
      regs_q[SP_IDX] <= SP_RESET;
      out_c_q        <= '0;
      out_d_q        <= '0;
`ifdef ADDR_STACK_BOUNDS_EN
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register take its next
      // value from the same pre-edge state, independent of statement order.
      regs_q  <= regs_d;
      out_c_q <= out_c_d;
      out_d_q <= out_d_d;
`ifdef ADDR_STACK_BOUNDS_EN
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`endif
    end
  end

  assign bus.out_c = out_c_q;
  assign bus.out_d = out_d_q;
`ifdef ADDR_STACK_BOUNDS_EN
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_address_register_bank.sv
// Self-checking testbench for address_register_bank.
//
// An abstract model holds the register file as an int array and applies the
// bank's arithmetic rules with plain modular arithmetic. A negedge compare
// process checks every output against that model on every cycle after the
// first reset. Directed steps additionally check hand-computed literal
// values, which pins down the model itself.
//
// The stack-bound feature is followed through ADDR_STACK_BOUNDS_EN, so the
// same bench serves both builds.
module tb_address_register_bank;
  localparam int WIDTH    = 16;
  localparam int NUM_REGS = 4;
  localparam int MOD      = 1 << WIDTH;
  localparam int SP_MIN_I = 'h0080;
  localparam int SP_MAX_I = 'h00FF;
`ifdef ADDR_STACK_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n;

  address_register_bank_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) bus ();

  address_register_bank #(
    .WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .PC_RESET(16'h0000),
    .SP_RESET(16'h00FF), .SP_MIN(16'h0080), .SP_MAX(16'h00FF)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model of the bank.
  int m_reg [NUM_REGS];
  int m_c, m_d;
  bit m_ovf, m_unf;
  bit model_valid = 1'b0;

  function automatic int rd(input int sel);
    return (sel < NUM_REGS) ? m_reg[sel] : 0;
  endfunction

  task automatic model_step();
    int nxt [NUM_REGS];
    int sp;
    if (!reset_n) begin
      foreach (m_reg[k]) m_reg[k] = 0;
      m_reg[1] = 'h00FF;
      m_c = 0; m_d = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    m_c = rd(int'(bus.out_c_sel));
    m_d = rd(int'(bus.out_d_sel));
    foreach (nxt[k]) begin
      nxt[k] = m_reg[k];
      if (bus.reg_sel[k]) begin
        case (int'(bus.fun_sel))
          0: nxt[k] = 0;
          1: nxt[k] = int'(bus.i);
          2: nxt[k] = (m_reg[k] + 1) % MOD;
          default: nxt[k] = (m_reg[k] + MOD - 1) % MOD;
        endcase
      end
    end
    if (BOUNDS && bus.clear_flags) begin m_ovf = 0; m_unf = 0; end
    sp = m_reg[1];
    if (bus.push || bus.pop) nxt[1] = sp;
    if (bus.push && !bus.pop) begin
      if (BOUNDS && sp == SP_MIN_I) m_ovf = 1;
      else nxt[1] = (sp + MOD - 1) % MOD;
    end
    if (bus.pop && !bus.push) begin
      if (BOUNDS && sp == SP_MAX_I) m_unf = 1;
      else nxt[1] = (sp + 1) % MOD;
    end
    m_reg = nxt;
  endtask

  // Advance one clock edge and keep the model in lock-step with the DUT.
  task automatic tick();
    @(posedge clock);
    model_step();
    model_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    bus.reg_sel = '0; bus.fun_sel = 2'b00; bus.i = '0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear_flags = 1'b0;
  endtask

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_out_c", 32'(bus.out_c), 32'(m_c));
      check("model_out_d", 32'(bus.out_d), 32'(m_d));
      check("model_ovf", 32'(bus.stack_overflow), 32'(m_ovf));
      check("model_unf", 32'(bus.stack_underflow), 32'(m_unf));
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    bus.out_c_sel = '0; bus.out_d_sel = '0;
    tick(); tick();
    check("rst_out_c", 32'(bus.out_c), 32'h0);
    check("rst_out_d", 32'(bus.out_d), 32'h0);
    check("rst_ovf", 32'(bus.stack_overflow), 32'h0);
    check("rst_unf", 32'(bus.stack_underflow), 32'h0);

    // Reset values seen through the read ports.
    reset_n = 1'b1;
    bus.out_c_sel = 2'd1; bus.out_d_sel = 2'd0;
    tick();
    check("sp_reset", 32'(bus.out_c), 32'h00FF);
    check("pc_reset", 32'(bus.out_d), 32'h0000);

    // Load AR0: the read port still shows the old value one edge later,
    // and the loaded value after the next edge.
    bus.reg_sel = 4'b0100; bus.fun_sel = 2'b01; bus.i = 16'h1234; bus.out_c_sel = 2'd2;
    tick();
    check("load_no_bypass", 32'(bus.out_c), 32'h0000);
    idle();
    tick();
    check("load_visible", 32'(bus.out_c), 32'h1234);
    bus.reg_sel = 4'b0100; bus.fun_sel = 2'b10;
    tick(); idle(); tick();
    check("inc_1235", 32'(bus.out_c), 32'h1235);
    bus.reg_sel = 4'b0100; bus.fun_sel = 2'b01; bus.i = 16'hFFFF;
    tick(); bus.fun_sel = 2'b10;
    tick(); idle(); tick();
    check("inc_wrap", 32'(bus.out_c), 32'h0000);
    bus.reg_sel = 4'b0100; bus.fun_sel = 2'b11;
    tick(); idle(); tick();
    check("dec_wrap", 32'(bus.out_c), 32'hFFFF);

    // Multi-register write; SP is not selected and keeps its value.
    bus.reg_sel = 4'b1101; bus.fun_sel = 2'b01; bus.i = 16'hA5A5;
    tick(); idle();
    bus.out_c_sel = 2'd0; bus.out_d_sel = 2'd3;
    tick();
    check("multi_pc", 32'(bus.out_c), 32'hA5A5);
    check("multi_ar1", 32'(bus.out_d), 32'hA5A5);
    bus.out_c_sel = 2'd1; bus.out_d_sel = 2'd2;
    tick();
    check("multi_sp", 32'(bus.out_c), 32'h00FF);
    check("multi_ar0", 32'(bus.out_d), 32'hA5A5);
    bus.out_d_sel = 2'd1;
    tick();
    check("same_sel", 32'(bus.out_d), 32'h00FF);

    // Stack: 127 pushes bring SP from 00FF down to 0080.
    bus.out_c_sel = 2'd1;
    bus.push = 1'b1;
    for (int n = 0; n < 127; n++) tick();
    bus.push = 1'b0;
    tick();
    check("push127_sp", 32'(bus.out_c), 32'h0080);
    check("push127_ovf", 32'(bus.stack_overflow), 32'h0);
    bus.push = 1'b1;
    tick();
    check("push128_ovf", 32'(bus.stack_overflow), 32'(BOUNDS));
    bus.push = 1'b0;
    tick();
    check("push128_sp", 32'(bus.out_c), BOUNDS ? 32'h0080 : 32'h007F);
    bus.clear_flags = 1'b1;
    tick();
    check("clear_ovf", 32'(bus.stack_overflow), 32'h0);
    bus.clear_flags = 1'b0;
    bus.pop = 1'b1;
    for (int n = 0; n < (BOUNDS ? 127 : 128); n++) tick();
    bus.pop = 1'b0;
    tick();
    check("pop_back_sp", 32'(bus.out_c), 32'h00FF);
    // Pop at SP_MAX together with clear_flags: the new violation wins.
    bus.pop = 1'b1; bus.clear_flags = 1'b1;
    tick();
    check("pop_max_unf", 32'(bus.stack_underflow), 32'(BOUNDS));
    idle();
    tick();
    check("pop_max_sp", 32'(bus.out_c), BOUNDS ? 32'h00FF : 32'h0100);

    // Stack operations take priority over the load of SP.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    bus.push = 1'b1; bus.reg_sel = 4'b0010; bus.fun_sel = 2'b01; bus.i = 16'h0000;
    tick(); idle(); tick();
    check("prio_push_sp", 32'(bus.out_c), 32'h00FE);
    bus.push = 1'b1; bus.pop = 1'b1; bus.reg_sel = 4'b0010; bus.fun_sel = 2'b00;
    tick(); idle(); tick();
    check("push_pop_hold", 32'(bus.out_c), 32'h00FE);
    bus.push = 1'b1; bus.reg_sel = 4'b0110; bus.fun_sel = 2'b01; bus.i = 16'hBEEF;
    bus.out_d_sel = 2'd2;
    tick(); idle(); tick();
    check("push_other_sp", 32'(bus.out_c), 32'h00FD);
    check("push_other_ar0", 32'(bus.out_d), 32'hBEEF);

    // Pop from a loaded SP of FFFF wraps to 0000 without flags.
    bus.reg_sel = 4'b0010; bus.fun_sel = 2'b01; bus.i = 16'hFFFF;
    tick(); idle(); bus.pop = 1'b1;
    tick(); idle(); tick();
    check("pop_wrap_sp", 32'(bus.out_c), 32'h0000);
    check("pop_wrap_unf", 32'(bus.stack_underflow), 32'h0);

    // Reset in the middle of a push sequence.
    bus.push = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    check("midrst_out_c", 32'(bus.out_c), 32'h0000);
    check("midrst_out_d", 32'(bus.out_d), 32'h0000);
    reset_n = 1'b1; bus.push = 1'b0;
    tick();
    check("midrst_sp", 32'(bus.out_c), 32'h00FF);
    tick();

    model_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
